// File: rtl/tlp_wr2axis.sv
// tlp_wr2axis: accepts PCIe memory-write TLP payloads, drops others, and streams
// accepted beats through a reserving FIFO onto AXI-stream with video line framing.
module tlp_wr2axis #(
  parameter int MAX_PCIE_PAYLOAD_SIZE = 128,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        axi_clk,
  input  logic        axi_reset_n,
  input  logic [23:0] cfg_line_size,
  input  logic        tlp_req_to_send,
  output logic        tlp_grant,
  input  logic [6:0]  tlp_fmt_type,
  input  logic [9:0]  tlp_length_in_dw,
  input  logic        tlp_src_rdy_n,
  output logic        tlp_dst_rdy_n,
  input  logic [63:0] tlp_data,
  input  logic [63:0] tlp_address,
  input  logic [7:0]  tlp_ldwbe_fdwbe,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [1:0]  m_axis_tuser,
  output logic        m_axis_tlast,
  output logic [7:0]  err_count
);
  localparam int RES = MAX_PCIE_PAYLOAD_SIZE / 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;
  state_t state, state_nx;
  logic [9:0] beats, beats_left;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [66:0] mem [FIFO_DEPTH];
  logic [20:0] line_cnt, line_beats, line_len;
  logic ok, room, xfer, wr, rd, last, sol, eol, unused_ok;
  assign unused_ok = ^{tlp_address, tlp_ldwbe_fdwbe, cfg_line_size[2:0]};
  assign beats = tlp_length_in_dw == '0 ? 10'd512 : 10'(({1'b0, tlp_length_in_dw} + 11'd1) >> 1);
  assign ok = (tlp_fmt_type == 7'h40 || tlp_fmt_type == 7'h60) && tlp_length_in_dw != '0 &&
              {22'd0, tlp_length_in_dw} <= 32'(MAX_PCIE_PAYLOAD_SIZE / 4);
  // The output register holds a beat too, so it counts against the reservation.
  assign room = ({1'b0, count} + (CW+1)'(m_axis_tvalid)) <= (CW+1)'(FIFO_DEPTH - RES);
  assign xfer = state != IDLE && !tlp_src_rdy_n;
  assign wr = xfer && state == DATA;
  assign last = xfer && beats_left == 10'd1;
  assign rd = count != '0 && (!m_axis_tvalid || m_axis_tready);
  assign line_len = line_cnt == '0 ? cfg_line_size[23:3] : line_beats;
  assign sol = line_len != '0 && line_cnt == '0;
  assign eol = line_len != '0 && line_cnt == line_len - 21'd1;
  always_comb begin
    state_nx = state;
    tlp_grant = 1'b0;
    tlp_dst_rdy_n = state == IDLE;
    if (state == IDLE && tlp_req_to_send && room && axi_reset_n) begin
      tlp_grant = 1'b1;
      state_nx = ok ? DATA : DROP;
    end else if (last) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge axi_clk) begin
    if (!axi_reset_n) begin
      state <= IDLE;
      beats_left <= '0;
      err_count <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      line_cnt <= '0;
      line_beats <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tuser <= '0;
      m_axis_tlast <= 1'b0;
    end else begin
      state <= state_nx;
      if (tlp_grant) beats_left <= beats;
      else if (xfer) beats_left <= beats_left - 10'd1;
      if (tlp_grant && !ok && err_count != 8'hff) err_count <= err_count + 8'd1;
      if (line_cnt == '0) line_beats <= cfg_line_size[23:3];
      if (wr) begin
        wr_ptr <= wr_ptr == AW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
        line_cnt <= (eol || line_len == '0) ? '0 : line_cnt + 21'd1;
      end
      if (rd) begin
        {m_axis_tlast, m_axis_tuser, m_axis_tdata} <= mem[rd_ptr];
        rd_ptr <= rd_ptr == AW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      end
      m_axis_tvalid <= rd || (m_axis_tvalid && !m_axis_tready);
      count <= count + CW'(wr) - CW'(rd);
    end
  end
  // Unframed mode marks the TLP end in tlast; framed mode mirrors end-of-line.
  always_ff @(posedge axi_clk)
    if (wr) mem[wr_ptr] <= {line_len == '0 ? last : eol, eol, sol, tlp_data};
  always_ff @(posedge axi_clk)
    if (axi_reset_n && wr && !rd) assert (count < CW'(FIFO_DEPTH));
endmodule

// File: tb/tb_tlp_wr2axis.sv
// tb_tlp_wr2axis: randomized scoreboard bench for tlp_wr2axis.
module tb_tlp_wr2axis;
  localparam int MAXP = 128;
  localparam int DEPTH = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic [23:0] cfg = '0;
  logic req = 1'b0;
  logic grant;
  logic [6:0] fmt = '0;
  logic [9:0] len = '0;
  logic src_rdy_n = 1'b1;
  logic dst_rdy_n;
  logic [63:0] data = '0;
  logic [63:0] addr = '0;
  logic [7:0] be = 8'hff;
  logic tvalid;
  logic tready = 1'b0;
  logic [63:0] tdata;
  logic [1:0] tuser;
  logic tlast;
  logic [7:0] err;
  int n_cmp = 0;
  int n_bad = 0;
  logic [66:0] exp_q [$];
  int ready_mode = 0;
  int phase = 0;
  int exp_err = 0;
  logic [63:0] seq = '0;

  tlp_wr2axis #(.MAX_PCIE_PAYLOAD_SIZE(MAXP), .FIFO_DEPTH(DEPTH)) dut (
    .axi_clk(clk), .axi_reset_n(rst_n), .cfg_line_size(cfg),
    .tlp_req_to_send(req), .tlp_grant(grant), .tlp_fmt_type(fmt),
    .tlp_length_in_dw(len), .tlp_src_rdy_n(src_rdy_n), .tlp_dst_rdy_n(dst_rdy_n),
    .tlp_data(data), .tlp_address(addr), .tlp_ldwbe_fdwbe(be),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast), .err_count(err)
  );

  always @(posedge clk) begin
    #1;
    tready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode == 1;
  end

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (tvalid && tready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got %h expected none", {tlast, tuser, tdata});
      end else chk("stream_beat", {tlast, tuser, tdata}, exp_q.pop_front());
    end

  task automatic send_tlp(input logic [6:0] f, input logic [9:0] l, input bit gaps,
                          input bit rnd, input int abort_at);
    int nb, i, guard, L, p;
    bit acc;
    logic [66:0] e;
    nb = (l == 0) ? 512 : (int'(l) + 1) / 2;
    acc = (f == 7'h40 || f == 7'h60) && l != 0 && int'(l) <= MAXP / 4;
    @(posedge clk); #1;
    req = 1'b1; fmt = f; len = l;
    guard = 0;
    do begin @(negedge clk); #1; guard++; end while (!grant && guard < 3000);
    if (!grant) begin
      n_cmp++;
      n_bad++;
      $display("FAIL grant_timeout: got no grant expected grant");
      req = 1'b0;
      return;
    end
    chk("grant_room", 67'(exp_q.size() <= DEPTH - MAXP / 8), 67'd1);
    if (!acc && exp_err < 255) exp_err++;
    @(posedge clk); #1;
    req = 1'b0;
    i = 0;
    guard = 0;
    while (i < nb && guard < 5000 && i != abort_at) begin
      src_rdy_n = gaps && ($urandom_range(0, 2) == 0);
      data = rnd ? {$urandom, $urandom} : (64'hAA00_0000_0000_0000 | seq);
      @(negedge clk); #1;
      if (!src_rdy_n && !dst_rdy_n) begin
        if (acc) begin
          L = int'(cfg[23:3]);
          if (L == 0) e = {i == nb - 1, 2'b00, data};
          else begin
            p = phase % L;
            e = {p == L - 1, p == L - 1, p == 0, data};
            phase++;
          end
          exp_q.push_back(e);
        end
        seq++;
        i++;
      end
      guard++;
      @(posedge clk); #1;
    end
    src_rdy_n = 1'b1;
    if (abort_at < 0) chk("tlp_beats_sent", 67'(i), 67'(nb));
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || tvalid) && g < 4000) begin @(negedge clk); #1; g++; end
    chk(name, 67'(exp_q.size()), 67'd0);
  endtask

  initial begin
    int g;
    logic [6:0] f;
    req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 67'(grant), 67'd0);
    chk("rst_dst_rdy_n", 67'(dst_rdy_n), 67'd1);
    chk("rst_stream", {tvalid, tlast, tuser, tdata[62:0]}, 67'd0);
    chk("rst_err", 67'(err), 67'd0);
    #1;
    req = 1'b0;
    rst_n = 1'b1;

    cfg = 24'h1000; phase = 0; seq = '0; ready_mode = 1;
    for (int t = 0; t < 32; t++) send_tlp(7'h60, 10'd32, 1'b0, 1'b0, -1);
    drain("mwr512_drain");

    cfg = '0; phase = 0; ready_mode = 0;
    send_tlp(7'h60, 10'd32, 1'b0, 1'b1, -1);
    send_tlp(7'h40, 10'd32, 1'b0, 1'b1, -1);
    @(posedge clk); #1;
    req = 1'b1; fmt = 7'h60; len = 10'd32;
    g = 0;
    repeat (40) begin @(negedge clk); #1; if (grant) g++; end
    chk("full_no_grant", 67'(g), 67'd0);
    chk("full_tvalid", 67'(tvalid), 67'd1);
    ready_mode = 1;
    send_tlp(7'h60, 10'd32, 1'b0, 1'b1, -1);
    drain("backpressure_drain");

    send_tlp(7'h00, 10'd4, 1'b0, 1'b1, -1);
    send_tlp(7'h60, 10'd8, 1'b0, 1'b1, -1);
    drain("mrd_drain");
    chk("err_after_mrd", 67'(err), 67'(exp_err));
    send_tlp(7'h60, 10'd33, 1'b0, 1'b1, -1);
    chk("err_len33", 67'(err), 67'(exp_err));
    send_tlp(7'h40, 10'd0, 1'b0, 1'b1, -1);
    send_tlp(7'h40, 10'd1, 1'b0, 1'b1, -1);
    send_tlp(7'h40, 10'd32, 1'b0, 1'b1, -1);
    drain("boundary_drain");
    chk("err_len0", 67'(err), 67'(exp_err));
    for (int t = 0; t < 300; t++) send_tlp(7'h60, 10'd33, 1'b0, 1'b1, -1);
    chk("err_saturated", 67'(err), 67'd255);

    cfg = 24'h80; phase = 0; ready_mode = 0;
    send_tlp(7'h60, 10'd6, 1'b0, 1'b1, -1);
    send_tlp(7'h60, 10'd32, 1'b0, 1'b1, 5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    phase = 0;
    exp_err = 0;
    chk("midrst_dst_rdy_n", 67'(dst_rdy_n), 67'd1);
    chk("midrst_stream", {tvalid, tlast, tuser, tdata[62:0]}, 67'd0);
    chk("midrst_err", 67'(err), 67'd0);
    ready_mode = 1;
    g = 0;
    repeat (20) begin @(negedge clk); #1; if (tvalid) g++; end
    chk("midrst_no_partial", 67'(g), 67'd0);
    send_tlp(7'h60, 10'd32, 1'b0, 1'b1, -1);
    drain("midrst_drain");

    cfg = 24'h20; phase = 0; ready_mode = 2;
    for (int t = 0; t < 40; t++) begin
      g = $urandom_range(0, 3);
      f = g == 0 ? 7'h40 : g == 2 ? 7'h00 : 7'h60;
      send_tlp(f, 10'($urandom_range(1, 40)), 1'b1, 1'b1, -1);
    end
    drain("random_drain");
    chk("random_err", 67'(err), 67'(exp_err));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
